// File: rtl/gshare_spec_bp_if.sv
// Fetch/resolve bundle for the gshare_spec_bp predictor.
// master: fetch + execute side driving lookups and resolves.
// slave: the predictor itself.
interface gshare_spec_bp_if #(
    parameter int GHR_BITS = 8
);
    logic                init_busy_o;
    logic                fetch_valid_i;
    logic [31:0]         fetch_pc_i;
    logic                pred_taken_o;
    logic [GHR_BITS-1:0] pred_ghr_o;
    logic                update_en_i;
    logic [31:0]         update_pc_i;
    logic [GHR_BITS-1:0] update_ghr_i;
    logic                update_taken_i;
    logic                update_mispredict_i;
    logic [31:0]         stat_updates_o;
    logic [31:0]         stat_mispred_o;

    modport master (
        input  init_busy_o,
        output fetch_valid_i,
        output fetch_pc_i,
        input  pred_taken_o,
        input  pred_ghr_o,
        output update_en_i,
        output update_pc_i,
        output update_ghr_i,
        output update_taken_i,
        output update_mispredict_i,
        input  stat_updates_o,
        input  stat_mispred_o
    );

    modport slave (
        output init_busy_o,
        input  fetch_valid_i,
        input  fetch_pc_i,
        output pred_taken_o,
        output pred_ghr_o,
        input  update_en_i,
        input  update_pc_i,
        input  update_ghr_i,
        input  update_taken_i,
        input  update_mispredict_i,
        output stat_updates_o,
        output stat_mispred_o
    );
endinterface

// File: rtl/gshare_spec_bp.sv
// gshare direction predictor with a speculative global history register.
// Each prediction returns the history it used as a checkpoint; resolves hand
// it back so training indexes the same entry that made the prediction, and a
// mispredict rebuilds the speculative history from that checkpoint.
// The pattern table has no reset; a sequential INIT pass clears it.
// Optional macro GSHARE_STATS_EN adds saturating update/mispredict counters.
module gshare_spec_bp #(
    parameter int INDEX_BITS = 10,
    parameter int GHR_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int PC_LSB     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    gshare_spec_bp_if.slave  bp
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                 state;
    logic [INDEX_BITS-1:0]  init_ptr;
    logic [GHR_BITS-1:0]    spec_ghr;
    logic                   init_busy;

    logic [CTR_BITS-1:0]    pht [ENTRIES];

    logic [INDEX_BITS-1:0]  fetch_ghr_ext;
    logic [INDEX_BITS-1:0]  upd_ghr_ext;
    logic [INDEX_BITS-1:0]  fetch_idx;
    logic [INDEX_BITS-1:0]  upd_idx;
    logic [CTR_BITS-1:0]    fetch_ctr;
    logic [CTR_BITS-1:0]    upd_ctr;
    logic [CTR_BITS-1:0]    upd_next;
    logic                   pred_taken;
    logic                   upd_fire;
    logic                   repair;
    logic                   unused_pc_bits;

    // Zero-extend both histories to index width (works when GHR_BITS == INDEX_BITS too)
    always_comb begin
        fetch_ghr_ext = '0;
        upd_ghr_ext   = '0;
        fetch_ghr_ext[GHR_BITS-1:0] = spec_ghr;
        upd_ghr_ext[GHR_BITS-1:0]   = bp.update_ghr_i;
    end

    assign fetch_idx = bp.fetch_pc_i[PC_LSB +: INDEX_BITS] ^ fetch_ghr_ext;
    assign upd_idx   = bp.update_pc_i[PC_LSB +: INDEX_BITS] ^ upd_ghr_ext;

    assign fetch_ctr  = pht[fetch_idx];
    assign upd_ctr    = pht[upd_idx];
    assign pred_taken = ~init_busy & fetch_ctr[CTR_BITS-1];

    assign upd_fire = (state == RUN) & bp.update_en_i;
    assign repair   = upd_fire & bp.update_mispredict_i;

    assign unused_pc_bits = ^{bp.fetch_pc_i, bp.update_pc_i};

    // Saturating step of the counter addressed by the resolving branch
    always_comb begin
        upd_next = upd_ctr;
        if (bp.update_taken_i) begin
            if (upd_ctr != {CTR_BITS{1'b1}}) upd_next = upd_ctr + 1'b1;
        end else begin
            if (upd_ctr != '0) upd_next = upd_ctr - 1'b1;
        end
    end

    // Init/run control and speculative history: mispredict repair beats fetch shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_ptr  <= '0;
            spec_ghr  <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == {INDEX_BITS{1'b1}}) begin
                        state     <= RUN;
                        init_busy <= 1'b0;
                    end
                end
                RUN: begin
                    if (repair) begin
                        spec_ghr <= {bp.update_ghr_i[GHR_BITS-2:0], bp.update_taken_i};
                    end else if (bp.fetch_valid_i) begin
                        spec_ghr <= {spec_ghr[GHR_BITS-2:0], pred_taken};
                    end
                end
                default: begin
                    state     <= INIT;
                    init_ptr  <= '0;
                    init_busy <= 1'b1;
                end
            endcase
        end
    end

    // Single write port into the table: clear sweep during INIT, training in RUN
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            pht[init_ptr] <= CTR_INIT;
        end else if (bp.update_en_i) begin
            pht[upd_idx] <= upd_next;
        end
    end

    assign bp.init_busy_o  = init_busy;
    assign bp.pred_taken_o = pred_taken;
    assign bp.pred_ghr_o   = spec_ghr;

`ifdef GSHARE_STATS_EN
    logic [31:0] stat_updates;
    logic [31:0] stat_mispred;

    // Saturating counts of accepted resolves and of mispredicts among them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_updates <= '0;
            stat_mispred <= '0;
        end else begin
            if (upd_fire && (stat_updates != 32'hFFFF_FFFF)) stat_updates <= stat_updates + 32'd1;
            if (repair && (stat_mispred != 32'hFFFF_FFFF)) stat_mispred <= stat_mispred + 32'd1;
        end
    end

    assign bp.stat_updates_o = stat_updates;
    assign bp.stat_mispred_o = stat_mispred;
`else
    assign bp.stat_updates_o = '0;
    assign bp.stat_mispred_o = '0;
`endif

endmodule
